// File: rtl/life_run_if.sv
// life_run_if: control/status bundle between the run scheduler and its keyboard decoder, grid engine and grid RAM.
// master: scheduler side; takes start/pause/clear/manual/setting/modify levels and step_done,
//         and drives step_req, the RAM write port (wr_en/wr_addr/wr_toggle), cursor_x/cursor_y, state and gen_count.
// slave:  environment side, the mirror image of master.
interface life_run_if #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 64
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  logic start, pause, clear, manual, modify, step_done;
  logic [3:0] setting;
  logic step_req, wr_en, wr_toggle;
  logic [XW+YW-1:0] wr_addr;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic [2:0] state;
  logic [15:0] gen_count;
  modport master (
    input  start, pause, clear, manual, setting, modify, step_done,
    output step_req, wr_en, wr_addr, wr_toggle, cursor_x, cursor_y, state, gen_count
  );
  modport slave (
    output start, pause, clear, manual, setting, modify, step_done,
    input  step_req, wr_en, wr_addr, wr_toggle, cursor_x, cursor_y, state, gen_count
  );
endinterface

// File: rtl/life_run_scheduler.sv
// life_run_scheduler: run/pause/clear/edit sequencer for a Game of Life grid engine and its cell RAM.
// clk_in, reset (async, active-high) are plain ports; everything else is on bus (life_run_if.master):
//   keyboard levels start/pause/clear/manual/modify/setting, step_done from the engine,
//   step_req to the engine, wr_en/wr_addr/wr_toggle to the grid RAM, cursor_x/cursor_y, state, gen_count.
module life_run_scheduler #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 64,
  parameter int TICK_DIV = 5000000
) (
  input logic clk_in,
  input logic reset,
  life_run_if.master bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int AW = XW + YW;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_STEP = 3'd2, S_CLEAR = 3'd3, S_EDIT = 3'd4;
  localparam logic [AW-1:0] LAST = AW'(GRID_W * GRID_H - 1);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);
  logic [2:0] st;
  logic [CW-1:0] cnt;
  logic [15:0] gen;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic step_req, wr_en, wr_toggle;
  logic [AW-1:0] wr_addr;
  logic p_start, p_pause, p_clear, p_modify;
  logic [3:0] p_set;
  logic pend_pause, pend_clear;
  logic r_start, r_pause, r_clear, r_modify;
  logic [3:0] r_set;
  assign r_start  = bus.start & ~p_start;
  assign r_pause  = bus.pause & ~p_pause;
  assign r_clear  = bus.clear & ~p_clear;
  assign r_modify = bus.modify & ~p_modify;
  assign r_set    = bus.setting & ~p_set;
  assign bus.state     = st;
  assign bus.gen_count = gen;
  assign bus.cursor_x  = cx;
  assign bus.cursor_y  = cy;
  assign bus.step_req  = step_req;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_toggle = wr_toggle;
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      st <= S_IDLE;
      cnt <= '0;
      gen <= '0;
      cx <= '0;
      cy <= '0;
      step_req <= 1'b0;
      wr_en <= 1'b0;
      wr_toggle <= 1'b0;
      wr_addr <= '0;
      {p_start, p_pause, p_clear, p_modify, p_set} <= '0;
      {pend_pause, pend_clear} <= 2'b00;
    end else begin
      {p_start, p_pause, p_clear, p_modify, p_set} <= {bus.start, bus.pause, bus.clear, bus.modify, bus.setting};
      // write port and step request are single-cycle unless re-asserted below
      step_req <= 1'b0;
      wr_en <= 1'b0;
      wr_toggle <= 1'b0;
      wr_addr <= '0;
      case (st)
        S_IDLE: begin
          if (r_clear) begin
            st <= S_CLEAR;
            wr_en <= 1'b1;
          end else if (r_start) begin
            st <= S_WAIT;
            cnt <= '0;
          end else if (bus.manual) st <= S_EDIT;
        end
        S_WAIT: begin
          if (r_clear) begin
            st <= S_CLEAR;
            wr_en <= 1'b1;
          end else if (r_pause) st <= S_IDLE;
          else if (cnt == TERM) begin
            st <= S_STEP;
            step_req <= 1'b1;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        end
        S_STEP: begin
          // pause/clear arriving together with step_done count as already latched
          if (bus.step_done) begin
            gen <= gen + 16'd1;
            {pend_pause, pend_clear} <= 2'b00;
            if (pend_clear | r_clear) begin
              st <= S_CLEAR;
              wr_en <= 1'b1;
            end else if (pend_pause | r_pause) st <= S_IDLE;
            else begin
              st <= S_WAIT;
              cnt <= '0;
            end
          end else begin
            pend_pause <= pend_pause | r_pause;
            pend_clear <= pend_clear | r_clear;
          end
        end
        S_CLEAR: begin
          // wr_addr holds the address being written this cycle; wr_en is pre-set on entry
          if (wr_addr == LAST) begin
            st <= S_IDLE;
            gen <= '0;
          end else begin
            wr_en <= 1'b1;
            wr_addr <= wr_addr + 1'b1;
          end
        end
        S_EDIT: begin
          if (r_clear) begin
            st <= S_CLEAR;
            wr_en <= 1'b1;
          end else if (r_start) begin
            st <= S_WAIT;
            cnt <= '0;
          end else if (!bus.manual) st <= S_IDLE;
          else begin
            if (r_modify) begin
              wr_en <= 1'b1;
              wr_toggle <= 1'b1;
              wr_addr <= {cy, cx};
            end
            if (r_set[0]) cx <= cx - 1'b1;
            else if (r_set[1]) cy <= cy - 1'b1;
            else if (r_set[2]) cy <= cy + 1'b1;
            else if (r_set[3]) cx <= cx + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
